timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 154 +++++++++++++++
 tb/tb_timer_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbiter that lends one shared up-counter to N
// requesters. The winner's interval length is latched at grant time. The
// counter then steps 0..limit, and done is pulsed for the owner on completion.
// A requester that drops req while it owns the counter aborts its interval
// without a done pulse.

module timer_arbiter #(
  parameter int BITS = 4,
  parameter int N    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N*BITS-1:0] len,
  input  logic              hold,
  output logic [N-1:0]      grant,
  output logic [N-1:0]      done,
  output logic [BITS-1:0]   cnt,
  output logic              busy
);

  // Width of the round-robin pointer and of the owner index.
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Registered state and its next-state values.
  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q,   ptr_d;
  logic [PW-1:0]   idx_q,   idx_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q,  done_d;
  logic [BITS-1:0] cnt_q,   cnt_d;
  logic [BITS-1:0] limit_q, limit_d;

  // Round-robin selection results.
  logic [N-1:0]    elig_s;
  logic            sel_found_s;
  logic [PW-1:0]   sel_idx_s;
  logic [N-1:0]    sel_onehot_s;
  logic [BITS-1:0] sel_len_s;
  logic [PW-1:0]   ptr_next_s;

  // Pick the first eligible requester, searching circularly from ptr.
  // A requester whose done is pulsing in this cycle is excluded, so it
  // cannot win again in its own done cycle.
  always_comb begin
    elig_s      = req & ~done_q;
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_found_s && elig_s[(int'(ptr_q) + k) % N]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = PW'((int'(ptr_q) + k) % N);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Decode the selected index into a one-hot grant. Also extract that
  // requester's interval length and compute the pointer that follows the
  // current owner.
  always_comb begin
    sel_onehot_s = {{(N-1){1'b0}}, 1'b1} << sel_idx_s;
    sel_len_s    = len[int'(sel_idx_s)*BITS +: BITS];
    if (idx_q == PW'(N-1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = idx_q + PW'(1);
    end
  end

  // Next-state logic. In COUNT the checks run in this order: abort first,
  // then terminal count, then hold, then increment.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          state_d = COUNT;
          idx_d   = sel_idx_s;
          grant_d = sel_onehot_s;
          cnt_d   = '0;
          limit_d = sel_len_s;
        end else begin
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (!req[idx_q]) begin
          // The owner walked away: release without a done pulse.
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = ptr_next_s;
        end else if ((cnt_q == limit_q) && !hold) begin
          state_d = IDLE;
          done_d  = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = ptr_next_s;
        end else if (hold) begin
          // Freeze the counter. A count already at the limit stays there.
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers. Synchronous reset overrides everything, even mid-count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign cnt   = cnt_q;
  assign busy  = (state_q == COUNT);

endmodule

// File: tb/tb_timer_arbiter.sv
// Testbench for timer_arbiter. Every cycle is compared against a behavioural
// model that tracks an owner number, elapsed count and round-robin pointer.
// Directed scenarios also carry explicit constant checks.

module tb_timer_arbiter;
  localparam int BITS = 4;
  localparam int N    = 4;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*BITS-1:0] len;
  logic              hold;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic [BITS-1:0]   cnt;
  logic              busy;

  int n_vec;
  int n_bad;

  // Reference model state.
  int          m_owner;
  int          m_cnt;
  int          m_limit;
  int          m_ptr;
  logic [N-1:0] m_done;

  timer_arbiter #(.BITS(BITS), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .hold  (hold),
    .grant (grant),
    .done  (done),
    .cnt   (cnt),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge, using the inputs present at that edge.
  task automatic model_step();
    logic [N-1:0] elig;
    logic [N-1:0] nd;
    int           i;
    nd = '0;
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_limit = 0; m_ptr = 0; m_done = '0;
      return;
    end
    if (m_owner < 0) begin
      elig  = req & ~m_done;
      m_cnt = 0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (m_owner < 0 && elig[i]) begin
          m_owner = i;
          m_limit = int'(len[i*BITS +: BITS]);
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
    end else if (m_cnt == m_limit && !hold) begin
      nd[m_owner] = 1'b1;
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
    end else if (!hold) begin
      m_cnt = m_cnt + 1;
    end
    m_done = nd;
  endtask

  // One clock: update the model at the edge, then compare every output 1 time unit later.
  task automatic cyc();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    chk("done",  32'(done),  32'(m_done));
    chk("cnt",   32'(cnt),   32'(m_cnt));
    chk("busy",  32'(busy),  32'(m_owner >= 0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  logic [N-1:0] prev_g;
  logic [N-1:0] gr_seq [5];
  int           gr_cyc [5];
  logic [N-1:0] dn_seq [5];
  int           dn_cyc [5];
  int           ngr;
  int           ndn;

  initial begin
    n_vec = 0; n_bad = 0;
    m_owner = -1; m_cnt = 0; m_limit = 0; m_ptr = 0; m_done = '0;
    reset = 1'b1; req = '0; len = '0; hold = 1'b0;
    #1;
    cyc();
    cyc();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    reset = 1'b0;

    // Single request of length 3: counts 0..3, then done for one cycle.
    req = 4'b0001; len = {4'd7, 4'd9, 4'd1, 4'd3};
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk("single_cnt",   32'(cnt),   32'(j));
      chk("single_grant", 32'(grant), 32'h1);
      chk("single_busy",  32'(busy),  32'h1);
    end
    cyc();
    chk("single_done",  32'(done),  32'h1);
    chk("single_gnone", 32'(grant), 32'h0);
    req = 4'b0000;
    cyc();
    chk("single_done_once", 32'(done), 32'h0);

    // Reset while counting with cnt=2; afterwards requester 0 wins.
    do_reset();
    req = 4'b0001; len = {4'd0, 4'd0, 4'd0, 4'd5};
    cyc(); cyc(); cyc();
    chk("rstmid_pre_cnt", 32'(cnt), 32'd2);
    reset = 1'b1; req = 4'b1111;
    cyc();
    chk("rstmid_grant", 32'(grant), 32'h0);
    chk("rstmid_done",  32'(done),  32'h0);
    chk("rstmid_cnt",   32'(cnt),   32'h0);
    chk("rstmid_busy",  32'(busy),  32'h0);
    reset = 1'b0;
    cyc();
    chk("rstmid_first", 32'(grant), 32'h1);

    // Fairness: all requesting with length 1 gives order 0,1,2,3,0, three cycles apart.
    req = 4'b0000;
    do_reset();
    req = 4'b1111; len = {4'd1, 4'd1, 4'd1, 4'd1};
    prev_g = '0; ngr = 0; ndn = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      if (grant != '0 && grant != prev_g && ngr < 5) begin
        gr_seq[ngr] = grant; gr_cyc[ngr] = c; ngr++;
      end
      if (done != '0 && ndn < 5) begin
        dn_seq[ndn] = done; dn_cyc[ndn] = c; ndn++;
      end
      prev_g = grant;
    end
    chk("fair_ngrants", 32'(ngr), 32'd5);
    chk("fair_ndones",  32'(ndn), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("fair_gorder", 32'(gr_seq[i]), 32'(1) << (i % 4));
      chk("fair_dorder", 32'(dn_seq[i]), 32'(1) << (i % 4));
      if (i > 0) begin
        chk("fair_gspace", 32'(gr_cyc[i] - gr_cyc[i-1]), 32'd3);
        chk("fair_dspace", 32'(dn_cyc[i] - dn_cyc[i-1]), 32'd3);
      end
    end

    // Abort: requester 1 drops at cnt=2, no done, and the pointer moves to 2.
    req = 4'b0000;
    do_reset();
    req = 4'b0010; len = {4'd0, 4'd0, 4'd5, 4'd0};
    cyc(); cyc(); cyc();
    chk("abort_pre_cnt", 32'(cnt), 32'd2);
    req = 4'b0000;
    cyc();
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_cnt",   32'(cnt),   32'h0);
    chk("abort_done",  32'(done),  32'h0);
    req = 4'b1111;
    cyc();
    chk("abort_ptr2", 32'(grant), 32'h4);

    // Zero length: a single COUNT cycle, then done.
    req = 4'b0000;
    do_reset();
    req = 4'b0100; len = {4'd3, 4'd0, 4'd3, 4'd3};
    cyc();
    chk("zero_grant", 32'(grant), 32'h4);
    chk("zero_cnt",   32'(cnt),   32'h0);
    cyc();
    chk("zero_done",  32'(done),  32'h4);
    req = 4'b0000;
    cyc();

    // Hold for 2 cycles at cnt=1 delays done by 2 cycles.
    do_reset();
    req = 4'b0001; len = {4'd0, 4'd0, 4'd0, 4'd2};
    cyc(); cyc();
    hold = 1'b1;
    cyc(); chk("hold_cnt_a", 32'(cnt), 32'd1);
    cyc(); chk("hold_cnt_b", 32'(cnt), 32'd1);
    hold = 1'b0;
    cyc(); chk("hold_cnt_c", 32'(cnt), 32'd2);
    chk("hold_nodone", 32'(done), 32'h0);
    cyc(); chk("hold_done", 32'(done), 32'h1);
    req = 4'b0000;
    cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      len  = (N*BITS)'($urandom);
      hold = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
